aes128_inv_control_unit: RTL and testbench
==========================================

AES128_INV_CONTROL_UNIT -- requirements
Module: aes128_inv_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-003 SHALL have port start, input, 1, request to begin one decryption key sequence; sampled only in IDLE.
REQ-004 SHALL have port cipherkey, input, 128, the cipher key (round key K0); sampled in the cycle start is accepted.
REQ-005 SHALL have port busy, output, 1, high in EXPAND and DECRYPT.
REQ-006 SHALL have port round, output, 2, round type: 00 INITIAL, 01 INTERMEDIATE, 10 LAST.
REQ-007 SHALL have port round_idx, output, 4, index i of the round key currently on key.
REQ-008 SHALL have port key, output, 128, the current round key Ki, driven from the key register.
REQ-009 SHALL have port done, output, 1, single-cycle pulse in the final round (LAST) cycle.

Function
REQ-010 SHALL implement FSM states IDLE, EXPAND, DECRYPT and DONE_S.
REQ-011 IDLE SHALL go to EXPAND on start; it SHALL load key_reg with cipherkey and set cnt to 1.
REQ-012 EXPAND SHALL apply per cycle key_reg <= fwd_step(key_reg, rcon(cnt)), then cnt++.
REQ-013 EXPAND SHALL go to DECRYPT on the cycle it applies cnt==10, leaving cnt=10 and key_reg=K10.
REQ-014 DECRYPT SHALL drive round_idx=cnt and key=Ki.
REQ-015 DECRYPT round type SHALL be: cnt==10 -> INITIAL; cnt 9..1 -> INTERMEDIATE; cnt==0 -> LAST with done=1.
REQ-016 DECRYPT SHALL apply per cycle with cnt>0 key_reg <= inv_step(key_reg, rcon(cnt)), then cnt--.
REQ-017 DECRYPT SHALL go to DONE_S after the cnt==0 cycle; DONE_S SHALL go to IDLE unconditionally after one cycle.
REQ-018 rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1B,36 in the most significant byte, with the other bytes zero.
REQ-019 fwd_step SHALL be the FIPS-197 expansion: w4=w0^SubWord(RotWord(w3))^rcon, w5=w4^w1, w6=w5^w2, w7=w6^w3.
REQ-020 inv_step SHALL be the exact inverse: w3=w7^w6, w2=w6^w5, w1=w5^w4, w0=w4^SubWord(RotWord(w3))^rcon.
REQ-021 Latency SHALL be: start accepted at edge T gives DECRYPT at T+11..T+21, done at T+21, IDLE at T+23.
REQ-022 start outside IDLE, including in DONE_S, SHALL be ignored; cipherkey changes after acceptance SHALL have no effect.
REQ-023 In IDLE and DONE_S the outputs SHALL be round=00, done=0, busy=0, key=key_reg and round_idx=cnt.

Reset
REQ-024 rst_n low SHALL force IDLE immediately, with cnt=0, key_reg=0, round=00, round_idx=0, busy=0 and done=0.
REQ-025 Reset mid-EXPAND or mid-DECRYPT SHALL abort without a done pulse; the first start after release SHALL perform a full sequence.

Configuration
REQ-026 Macro AES128_INV_KEY_CACHE_EN defined: the block SHALL hold cached_key, cached_k10 and cache_valid, all reset to 0.
REQ-027 With the cache, EXPAND->DECRYPT SHALL store cipherkey and K10 and set cache_valid.
REQ-028 With the cache, start with cache_valid and cipherkey==cached_key SHALL load K10 and go directly to DECRYPT (cnt=10), so done arrives at T+11.
REQ-029 Macro undefined: no cache storage SHALL exist and every start SHALL take the full EXPAND path.

Structure
REQ-030 Shared package aes128_pkg SHALL hold the FSM state encoding, the round-type encoding (INITIAL/INTERMEDIATE/LAST), NR=10 and the rcon table function.
REQ-031 SHALL have one sub-module, aes128_key_round, containing the 4-byte S-box SubWord and RotWord/rcon logic and exposing both fwd_step and inv_step outputs.

Verification
REQ-032 Key 2b7e151628aed2a6abf7158809cf4f3c, start -> first DECRYPT cycle key=d014f9a8c9ee2589e13f0cc8b6630ca6 with round=00 and round_idx=10.
REQ-033 Same run -> LAST cycle key=2b7e151628aed2a6abf7158809cf4f3c, round=10, done=1 exactly once, at T+21.
REQ-034 Key 000102030405060708090a0b0c0d0e0f -> K10=13111d7fe3944a17f307a78b4d2b30c5, with round_idx decreasing 10..0 one per cycle.
REQ-035 Pulse start during DECRYPT and during DONE_S -> ignored; the sequence and timing are unchanged and the block is back in IDLE at T+23.
REQ-036 Assert rst_n low at round_idx=5 -> immediate IDLE with all outputs 0; a restart completes correctly with no done pulse before it.
REQ-037 With AES128_INV_KEY_CACHE_EN, two back-to-back starts with the same key -> second done at T+11; a different key -> T+21.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 inverse key-schedule controller:
// FSM state and round-type encodings, round count and the rcon table.
package aes128_pkg;

   localparam int unsigned NR    = 10;
   localparam int unsigned KEY_W = 128;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXPAND  = 2'd1,
      DECRYPT = 2'd2,
      DONE_S  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      INITIAL      = 2'b00,
      INTERMEDIATE = 2'b01,
      LAST         = 2'b10
   } round_e;

   // Round constant for expansion step idx (1..10), placed in the top byte.
   function automatic logic [31:0] rcon(input logic [CNT_W-1:0] idx);
      logic [7:0] b;
      case (idx)
         4'd1:    b = 8'h01;
         4'd2:    b = 8'h02;
         4'd3:    b = 8'h04;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h10;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         4'd8:    b = 8'h80;
         4'd9:    b = 8'h1b;
         4'd10:   b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h000000};
   endfunction

endpackage

// File: rtl/aes128_key_round.sv
// One AES-128 key-schedule step in both directions: forward (Ki-1 -> Ki)
// and its exact inverse (Ki -> Ki-1), sharing the same rcon input.
module aes128_key_round
   import aes128_pkg::*;
(
   input  logic [KEY_W-1:0] i_key,
   input  logic [31:0]      i_rcon,
   output logic [KEY_W-1:0] o_fwd,
   output logic [KEY_W-1:0] o_inv
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // SubWord(RotWord(w)) ^ rcon
   function automatic logic [31:0] sub_rot(input logic [31:0] w, input logic [31:0] rc);
      logic [31:0] r;
      r = {w[23:0], w[31:24]};
      return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]} ^ rc;
   endfunction

   logic [31:0] w_w0, w_w1, w_w2, w_w3;
   logic [31:0] w_f4, w_f5, w_f6, w_f7;
   logic [31:0] w_i0, w_i1, w_i2, w_i3;

   assign w_w0 = i_key[127:96];
   assign w_w1 = i_key[95:64];
   assign w_w2 = i_key[63:32];
   assign w_w3 = i_key[31:0];

   // Forward expansion: input words are w0..w3, outputs w4..w7
   assign w_f4  = w_w0 ^ sub_rot(w_w3, i_rcon);
   assign w_f5  = w_f4 ^ w_w1;
   assign w_f6  = w_f5 ^ w_w2;
   assign w_f7  = w_f6 ^ w_w3;
   assign o_fwd = {w_f4, w_f5, w_f6, w_f7};

   // Inverse: input words are w4..w7, recover w0..w3
   assign w_i3  = w_w3 ^ w_w2;
   assign w_i2  = w_w2 ^ w_w1;
   assign w_i1  = w_w1 ^ w_w0;
   assign w_i0  = w_w0 ^ sub_rot(w_i3, i_rcon);
   assign o_inv = {w_i0, w_i1, w_i2, w_i3};

endmodule

// File: rtl/aes128_inv_control_unit.sv
// Decryption round-key sequencer: expands the cipher key forward to K10,
// then walks the schedule backwards presenting K10..K0 one per cycle.
// Optional build macro AES128_INV_KEY_CACHE_EN: remembers the last key and
// its K10 so a repeated key skips the forward expansion.
module aes128_inv_control_unit
   import aes128_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [KEY_W-1:0]  cipherkey,
   output logic              busy,
   output logic [1:0]        round,
   output logic [CNT_W-1:0]  round_idx,
   output logic [KEY_W-1:0]  key,
   output logic              done
);

   state_e             r_state, w_nxt_state;
   logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
   logic [KEY_W-1:0]   r_key, w_nxt_key;
   logic               r_busy, w_nxt_busy;
   round_e             r_round, w_nxt_round;
   logic               r_done, w_nxt_done;
   logic [KEY_W-1:0]   w_fwd, w_inv;
   logic               w_cache_hit;
   logic [KEY_W-1:0]   w_hit_key;

   aes128_key_round u_key_round (
      .i_key  (r_key),
      .i_rcon (rcon(r_cnt)),
      .o_fwd  (w_fwd),
      .o_inv  (w_inv)
   );

`ifdef AES128_INV_KEY_CACHE_EN
   logic [KEY_W-1:0] r_cached_key;
   logic [KEY_W-1:0] r_cached_k10;
   logic             r_cache_valid;

   assign w_cache_hit = r_cache_valid && (cipherkey == r_cached_key);
   assign w_hit_key   = r_cached_k10;

   // Capture the accepted key on a miss; publish it with K10 once expansion ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cached_key  <= '0;
         r_cached_k10  <= '0;
         r_cache_valid <= 1'b0;
      end else if (r_state == IDLE && start && !w_cache_hit) begin
         r_cached_key  <= cipherkey;
         r_cache_valid <= 1'b0;
      end else if (r_state == EXPAND && w_nxt_state == DECRYPT) begin
         r_cached_k10  <= w_fwd;
         r_cache_valid <= 1'b1;
      end
   end
`else
   assign w_cache_hit = 1'b0;
   assign w_hit_key   = '0;
`endif

   // Next-state, counter and key-register update
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_key   = r_key;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_cache_hit) begin
                  w_nxt_state = DECRYPT;
                  w_nxt_cnt   = CNT_W'(NR);
                  w_nxt_key   = w_hit_key;
               end else begin
                  w_nxt_state = EXPAND;
                  w_nxt_cnt   = CNT_W'(1);
                  w_nxt_key   = cipherkey;
               end
            end
         end
         EXPAND: begin
            w_nxt_key = w_fwd;
            if (r_cnt == CNT_W'(NR)) w_nxt_state = DECRYPT;
            else                     w_nxt_cnt   = r_cnt + CNT_W'(1);
         end
         DECRYPT: begin
            if (r_cnt != '0) begin
               w_nxt_key = w_inv;
               w_nxt_cnt = r_cnt - CNT_W'(1);
            end else begin
               w_nxt_state = DONE_S;
            end
         end
         DONE_S:  w_nxt_state = IDLE;
         default: w_nxt_state = IDLE;
      endcase
   end

   // Output look-ahead so the registered outputs line up with the state
   always_comb begin
      w_nxt_busy  = 1'b0;
      w_nxt_round = INITIAL;
      w_nxt_done  = 1'b0;
      if (w_nxt_state == EXPAND) w_nxt_busy = 1'b1;
      if (w_nxt_state == DECRYPT) begin
         w_nxt_busy = 1'b1;
         if (w_nxt_cnt == CNT_W'(NR)) begin
            w_nxt_round = INITIAL;
         end else if (w_nxt_cnt == '0) begin
            w_nxt_round = LAST;
            w_nxt_done  = 1'b1;
         end else begin
            w_nxt_round = INTERMEDIATE;
         end
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_key   <= '0;
         r_busy  <= 1'b0;
         r_round <= INITIAL;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_key   <= w_nxt_key;
         r_busy  <= w_nxt_busy;
         r_round <= w_nxt_round;
         r_done  <= w_nxt_done;
      end
   end

   assign busy      = r_busy;
   assign round     = r_round;
   assign round_idx = r_cnt;
   assign key       = r_key;
   assign done      = r_done;

endmodule

// File: tb/tb_aes128_inv_control_unit.sv
// Directed bench for the AES-128 inverse key-schedule controller.
module tb_aes128_inv_control_unit;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] cipherkey;
   logic         busy;
   logic [1:0]   round;
   logic [3:0]   round_idx;
   logic [127:0] key;
   logic         done;

   int n_vec;
   int n_err;

`ifdef AES128_INV_KEY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   localparam logic [127:0] KA0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KA9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KB0  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KB1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   aes128_inv_control_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cipherkey (cipherkey),
      .busy      (busy),
      .round     (round),
      .round_idx (round_idx),
      .key       (key),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Start one sequence and check every cycle up to the return to IDLE.
   // Phase k is the value seen at the k-th rising edge after acceptance.
   task automatic run_seq(input logic [127:0] k0, input logic [127:0] k10,
                          input logic [127:0] k1, input logic [127:0] k9,
                          input bit has_k9, input bit shortp, input bit inject,
                          input int stop_ph);
      int off;
      int ndone;
      int idx;
      logic [1:0] er;
      off   = shortp ? 10 : 0;
      ndone = 0;
      cipherkey = k0;
      start     = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 23 - off; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start     = 1'b0;
            cipherkey = ~k0;
         end
         if (k <= 10 - off) begin
            chk("exp_busy",  128'(busy),  128'(1));
            chk("exp_round", 128'(round), 128'(0));
            chk("exp_done",  128'(done),  128'(0));
         end else if (k <= 21 - off) begin
            idx = 21 - off - k;
            er  = (k == 11 - off) ? 2'b00 : (k == 21 - off) ? 2'b10 : 2'b01;
            chk("dec_busy",  128'(busy),      128'(1));
            chk("dec_idx",   128'(round_idx), 128'(idx));
            chk("dec_round", 128'(round),     128'(er));
            chk("dec_done",  128'(done),      128'(k == 21 - off));
         end else begin
            chk("tail_busy",  128'(busy),      128'(0));
            chk("tail_round", 128'(round),     128'(0));
            chk("tail_done",  128'(done),      128'(0));
            chk("tail_idx",   128'(round_idx), 128'(0));
            chk("tail_key",   key,             k0);
         end
         if (k == 11 - off)           chk("key_k10", key, k10);
         if (k == 12 - off && has_k9) chk("key_k9",  key, k9);
         if (k == 20 - off)           chk("key_k1",  key, k1);
         if (k == 21 - off)           chk("key_k0",  key, k0);
         if (done) ndone++;
         if (inject && (k == 15 - off || k == 22 - off)) begin
            start     = 1'b1;
            cipherkey = k10;
         end else begin
            start = 1'b0;
         end
         if (k == stop_ph) begin
            chk("abort_no_done", 128'(ndone), 128'(0));
            return;
         end
      end
      chk("done_count", 128'(ndone), 128'(1));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  128'(busy),      128'(0));
      chk({tag, "_round"}, 128'(round),     128'(0));
      chk({tag, "_idx"},   128'(round_idx), 128'(0));
      chk({tag, "_key"},   key,             128'(0));
      chk({tag, "_done"},  128'(done),      128'(0));
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      cipherkey = '0;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // FIPS key with start pulses injected in DECRYPT and DONE_S
      run_seq(KA0, KA10, KA1, KA9, 1'b1, 1'b0, 1'b1, 0);
      // Same key again: skips expansion only when the cache is built in
      run_seq(KA0, KA10, KA1, KA9, 1'b1, CACHE, 1'b0, 0);
      // Different key always takes the full path
      run_seq(KB0, KB10, KB1, '0, 1'b0, 1'b0, 1'b0, 0);

      // Abort at round_idx 5, then a clean restart
      run_seq(KA0, KA10, KA1, KA9, 1'b1, 1'b0, 1'b0, 16);
      chk("abort_idx", 128'(round_idx), 128'(5));
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      chk_all_zero("held_rst");
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("idle_done", 128'(done), 128'(0));
         chk("idle_busy", 128'(busy), 128'(0));
      end
      run_seq(KB0, KB10, KB1, '0, 1'b0, 1'b0, 1'b0, 0);
      run_seq(KB0, KB10, KB1, '0, 1'b0, CACHE, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
